seg_scan: RTL and testbench

//  Output side of the calculator: takes operand registers (reg_1, reg_2), the 8-bit

---
 rtl/seg_scan_if.sv | 23 ++
 rtl/seg_scan.sv | 213 +++++++++++++++++++++
 tb/tb_seg_scan.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// seg_scan_if: operand/result inputs and multiplexed 7-segment outputs of seg_scan.
// The master side drives operands and the update strobe; the slave side is the display block.
interface seg_scan_if;
    logic [3:0] reg_1;
    logic [3:0] reg_2;
    logic [7:0] result;
    logic       ovf;
    logic       upd;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] dig_n;
    logic       busy;

    modport master (
        output reg_1, reg_2, result, ovf, upd,
        input  seg_n, dp_n, dig_n, busy
    );

    modport slave (
        input  reg_1, reg_2, result, ovf, upd,
        output seg_n, dp_n, dig_n, busy
    );
endinterface

// File: rtl/seg_scan.sv
// seg_scan: snapshots operands/result on upd and scans them onto a 4-digit common-anode display.
// Optional RESULT_BCD_EN: result digits shown in decimal via a sequential double-dabble.
module seg_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic      clk_disp,
    input  logic      rst_n,
    seg_scan_if.slave bus
);
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CONV = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic [3:0]       cap_r1_q, cap_r2_q;
    logic [7:0]       cap_res_q;
    logic             cap_ovf_q;
    logic [3:0]       sh_dig_q [4];
    logic             sh_dash_q, sh_ovf_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       idx_q;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       dig_q, dig_d;
    logic             cap_go_s, done_s;
    logic [3:0]       res_hi_s, res_lo_s;
    logic             res_dash_s;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign cap_go_s = (bus.upd | pend_q) & (state_q == ST_IDLE);

`ifdef RESULT_BCD_EN
    logic [7:0]  bin_q;
    logic [7:0]  bcd_q;
    logic [3:0]  iter_q;
    logic [7:0]  bcd_adj_s;
    logic [15:0] dd_shift_s;

    function automatic logic [7:0] dd_adjust(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 2; i++) begin
            r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? (b[i*4 +: 4] + 4'd3) : b[i*4 +: 4];
        end
        return r;
    endfunction

    // Only tens/ones are kept; anything above 99 is shown as dashes instead.
    assign bcd_adj_s  = dd_adjust(bcd_q);
    assign dd_shift_s = {bcd_adj_s, bin_q} << 1;
    assign done_s     = (state_q == ST_CONV) && (iter_q == 4'd8);
    assign res_hi_s   = bcd_q[7:4];
    assign res_lo_s   = bcd_q[3:0];
    assign res_dash_s = (cap_res_q > 8'd99);

    // Double-dabble datapath: one shift/add-3 step per busy cycle.
    always_ff @(posedge clk_disp or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= 8'd0;
            bcd_q  <= 8'd0;
            iter_q <= 4'd0;
        end else if (cap_go_s) begin
            bin_q  <= bus.result;
            bcd_q  <= 8'd0;
            iter_q <= 4'd0;
        end else if ((state_q == ST_CONV) && !done_s) begin
            {bcd_q, bin_q} <= dd_shift_s;
            iter_q         <= iter_q + 4'd1;
        end
    end
`else
    assign done_s     = (state_q == ST_CONV);
    assign res_hi_s   = cap_res_q[7:4];
    assign res_lo_s   = cap_res_q[3:0];
    assign res_dash_s = 1'b0;
`endif

    // Snapshot FSM state and pending-update register.
    always_ff @(posedge clk_disp or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Snapshot FSM next state; updates arriving while busy collapse into one pending request.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (cap_go_s) begin
                    state_d = ST_CONV;
                    pend_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (bus.upd) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
                if (done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CONV;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    // Capture registers and the display shadow, which is committed whole on one edge.
    always_ff @(posedge clk_disp or negedge rst_n) begin
        if (!rst_n) begin
            cap_r1_q  <= 4'd0;
            cap_r2_q  <= 4'd0;
            cap_res_q <= 8'd0;
            cap_ovf_q <= 1'b0;
            for (int i = 0; i < 4; i++) sh_dig_q[i] <= 4'd0;
            sh_dash_q <= 1'b0;
            sh_ovf_q  <= 1'b0;
        end else begin
            if (cap_go_s) begin
                cap_r1_q  <= bus.reg_1;
                cap_r2_q  <= bus.reg_2;
                cap_res_q <= bus.result;
                cap_ovf_q <= bus.ovf;
            end
            if (done_s) begin
                sh_dig_q[3] <= cap_r1_q;
                sh_dig_q[2] <= cap_r2_q;
                sh_dig_q[1] <= res_hi_s;
                sh_dig_q[0] <= res_lo_s;
                sh_dash_q   <= res_dash_s;
                sh_ovf_q    <= cap_ovf_q;
            end
        end
    end

    // Slot timer and digit index.
    always_ff @(posedge clk_disp or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= 2'd0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            idx_q <= idx_q + 2'd1;
        end else begin
            div_q <= div_q + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // Digit drive: blank the start of every slot so the previous digit cannot ghost.
    always_comb begin
        seg_d = 7'h7F;
        dig_d = 4'hF;
        dp_d  = 1'b1;
        if (div_q < BLANK_END) begin
            seg_d = 7'h7F;
            dig_d = 4'hF;
            dp_d  = 1'b1;
        end else begin
            dig_d = ~(4'b0001 << idx_q);
            if (sh_dash_q && !idx_q[1]) begin
                seg_d = 7'h3F;
            end else begin
                seg_d = hex_to_seg(sh_dig_q[idx_q]);
            end
            dp_d = ~((idx_q == 2'd0) & sh_ovf_q);
        end
    end

    // Output registers.
    always_ff @(posedge clk_disp or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 7'h7F;
            dig_q <= 4'hF;
            dp_q  <= 1'b1;
        end else begin
            seg_q <= seg_d;
            dig_q <= dig_d;
            dp_q  <= dp_d;
        end
    end

    assign bus.seg_n = seg_q;
    assign bus.dig_n = dig_q;
    assign bus.dp_n  = dp_q;
    assign bus.busy  = (state_q == ST_CONV);
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: drives seg_scan with directed and random updates and checks every cycle
// against a timestamp-based display model built from the display rules.
module tb_seg_scan;
    localparam int RDIV = 8;
    localparam int BLK  = 2;
`ifdef RESULT_BCD_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 1;
`endif

    logic clk_disp = 1'b0;
    logic rst_n    = 1'b1;
    int   n_cmp    = 0;
    int   n_err    = 0;

    seg_scan_if bus ();

    seg_scan #(.REFRESH_DIV(RDIV), .BLANK_CYC(BLK)) dut (
        .clk_disp(clk_disp),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk_disp = ~clk_disp;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: edges since reset release, displayed digits, snapshot in flight.
    int e;
    int m_sh [4];
    bit m_dash, m_ovf, m_busy, m_pend;
    int m_cend;
    int c_r1, c_r2, c_res;
    bit c_ovf;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [6:0] es, input logic [3:0] ed,
                             input logic edp, input logic eb);
        check_val({tag, ".seg_n"}, 32'(bus.seg_n), 32'(es));
        check_val({tag, ".dig_n"}, 32'(bus.dig_n), 32'(ed));
        check_val({tag, ".dp_n"},  32'(bus.dp_n),  32'(edp));
        check_val({tag, ".busy"},  32'(bus.busy),  32'(eb));
    endtask

    task automatic model_reset();
        e = 0;
        for (int i = 0; i < 4; i++) m_sh[i] = 0;
        m_dash = 1'b0; m_ovf = 1'b0; m_busy = 1'b0; m_pend = 1'b0; m_cend = 0;
    endtask

    task automatic model_commit();
        m_sh[3] = c_r1;
        m_sh[2] = c_r2;
`ifdef RESULT_BCD_EN
        m_dash  = (c_res > 99);
        m_sh[1] = (c_res / 10) % 10;
        m_sh[0] = c_res % 10;
`else
        m_dash  = 1'b0;
        m_sh[1] = c_res / 16;
        m_sh[0] = c_res % 16;
`endif
        m_ovf = c_ovf;
    endtask

    // One clock: predict outputs from the pre-edge display, advance the model, then compare.
    task automatic step(input string tag);
        logic [6:0] es;
        logic [3:0] ed;
        logic       edp;
        int dv, ix;
        dv = e % RDIV;
        ix = (e / RDIV) % 4;
        if (dv < BLK) begin
            es = 7'h7F; ed = 4'hF; edp = 1'b1;
        end else begin
            ed  = ~(4'b0001 << ix);
            es  = (m_dash && ix < 2) ? 7'h3F : seg_tab[m_sh[ix]];
            edp = !(ix == 0 && m_ovf);
        end
        if (m_busy) begin
            if (bus.upd) m_pend = 1'b1;
            if (e == m_cend) begin
                model_commit();
                m_busy = 1'b0;
            end
        end else if (bus.upd || m_pend) begin
            c_r1 = int'(bus.reg_1); c_r2 = int'(bus.reg_2);
            c_res = int'(bus.result); c_ovf = bus.ovf;
            m_pend = 1'b0; m_busy = 1'b1; m_cend = e + LAT;
        end
        @(posedge clk_disp);
        #1;
        check_out(tag, es, ed, edp, m_busy);
        e++;
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_out({tag, ".async"}, 7'h7F, 4'hF, 1'b1, 1'b0);
        model_reset();
        repeat (3) begin
            @(posedge clk_disp);
            #1;
            check_out({tag, ".held"}, 7'h7F, 4'hF, 1'b1, 1'b0);
        end
        #2;
        rst_n = 1'b1;
    endtask

    task automatic set_in(input logic [3:0] r1, input logic [3:0] r2,
                          input logic [7:0] res, input logic ov, input logic up);
        bus.reg_1 = r1; bus.reg_2 = r2; bus.result = res; bus.ovf = ov; bus.upd = up;
    endtask

    initial begin
        set_in(4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
        model_reset();
        do_reset("rst0");
        repeat (40) step("scan");

        set_in(4'hA, 4'h3, 8'h3C, 1'b1, 1'b1);
        step("upd_a3");
        bus.upd = 1'b0;
        repeat (40) step("show_a3");

        set_in(4'h5, 4'hC, 8'd42, 1'b0, 1'b1);
        step("upd_42");
        bus.upd = 1'b0;
        repeat (40) step("show_42");

        set_in(4'h1, 4'h2, 8'd120, 1'b1, 1'b1);
        step("upd_120");
        bus.upd = 1'b0;
        repeat (40) step("show_120");

        set_in(4'h7, 4'h7, 8'd5, 1'b0, 1'b1);
        step("dbl_0");
        set_in(4'h8, 4'h9, 8'd77, 1'b0, 1'b1);
        step("dbl_1");
        set_in(4'hE, 4'hD, 8'd99, 1'b1, 1'b1);
        step("dbl_2");
        bus.upd = 1'b0;
        repeat (45) step("dbl_show");

        repeat (13) step("pre_rst");
        do_reset("rst_scan");
        repeat (36) step("post_rst");

        set_in(4'hF, 4'hF, 8'd200, 1'b1, 1'b1);
        step("conv_rst");
        bus.upd = 1'b0;
        repeat (2) step("conv_mid");
        do_reset("rst_conv");
        repeat (40) step("post_conv");

        for (int i = 0; i < 600; i++) begin
            set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 5) == 0));
            if (i == 300) do_reset("rst_rand");
            step("rand");
        end
        bus.upd = 1'b0;
        repeat (40) step("tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
